// File: rtl/uart_apb_bridge.sv
// APB slave to word-register-file bridge.
// Decodes one APB transfer per setup phase, issues a single write strobe or a
// single read pop towards the register file, and answers with one pready pulse.
// Every state action shows up on the ports one cycle after the FSM occupies the
// matching state, because all port-facing signals are registered.
//
// APB handshake: a transfer starts on a setup cycle (psel_i=1, penable_i=0)
// seen in IDLE. pready_o is high for exactly one cycle, and pslverr_o and
// prdata_o are only non-zero in that cycle. Once started, a transfer always
// runs to completion, even if psel_i drops, because a register write or a
// read pop cannot be undone.
module uart_apb_bridge #(
    parameter int          NUM_REGS  = 8,
    parameter logic [4:0]  PARK_ADDR = 5'h1F,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [7:0]  paddr_i,
    input  logic [31:0] pwdata_i,
    input  logic [3:0]  pstrb_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic [4:0]  reg_raddr_o,
    input  logic [31:0] reg_rdata_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_WAIT = 3'd2,
        RD_CAP  = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Last wait count before the capture state; unused when RD_LAT is 0.
    localparam logic [1:0] LAST_WAIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t      state;
    state_t      state_nx;
    logic        setup;
    logic        dec_err;
    logic [4:0]  idx_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        err_q;
    logic [1:0]  wait_cnt;
    logic        cap_en_q;
    logic [31:0] cap_q;
    logic        resp_q;
    logic        resp_err_q;
    logic        resp_rd_q;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    assign setup = psel_i && !penable_i;

    // Address/strobe decode of the transfer presented in the setup cycle.
    always_comb begin
        dec_err = 1'b0;
        if (paddr_i[1:0] != 2'b00)                       dec_err = 1'b1;
        if (paddr_i[7])                                  dec_err = 1'b1;
        if ({1'b0, paddr_i[6:2]} >= 6'(NUM_REGS))        dec_err = 1'b1;
        if (pwrite_i && (pstrb_i != 4'hF))               dec_err = 1'b1;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    if (dec_err)       state_nx = RESP;
                    else if (pwrite_i) state_nx = WR;
                    else               state_nx = RD_WAIT;
                end
            end
            WR:      state_nx = RESP;
            RD_WAIT: begin
                if (RD_LAT == 0)                 state_nx = RESP;
                else if (wait_cnt == LAST_WAIT)  state_nx = RD_CAP;
            end
            RD_CAP:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Latch the transfer and its decode result on the accepted setup cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q   <= 5'd0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else if ((state == IDLE) && setup) begin
            idx_q   <= paddr_i[6:2];
            wdata_q <= pwdata_i;
            write_q <= pwrite_i;
            err_q   <= dec_err;
        end
    end

    // Count cycles spent in RD_WAIT to line the capture up with RD_LAT.
    always_ff @(posedge clk_i) begin
        if (reset_i || (state != RD_WAIT)) wait_cnt <= 2'd0;
        else                               wait_cnt <= wait_cnt + 2'd1;
    end

    // Registered regfile strobes, read capture and response flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            reg_we_o    <= 1'b0;
            reg_waddr_o <= 5'd0;
            reg_wdata_o <= 32'd0;
            reg_raddr_o <= PARK_ADDR;
            cap_en_q    <= 1'b0;
            cap_q       <= 32'd0;
            resp_q      <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_rd_q   <= 1'b0;
        end else begin
            reg_we_o <= (state == WR);
            if (state == WR) begin
                reg_waddr_o <= idx_q;
                reg_wdata_o <= wdata_q;
            end
            // Only the first RD_WAIT cycle leaves the park address, so a
            // read-popped entry advances once per APB read.
            reg_raddr_o <= ((state == RD_WAIT) && (wait_cnt == 2'd0)) ? idx_q : PARK_ADDR;
            // Capture lands RD_LAT cycles after the read address appears.
            cap_en_q    <= (state == RD_CAP) || ((RD_LAT == 0) && (state == RD_WAIT));
            if (cap_en_q) cap_q <= reg_rdata_i;
            resp_q      <= (state == RESP);
            resp_err_q  <= (state == RESP) && err_q;
            resp_rd_q   <= (state == RESP) && !err_q && !write_q;
        end
    end

    assign pready_o  = resp_q;
    assign pslverr_o = resp_err_q;
    assign prdata_o  = resp_rd_q ? cap_q : 32'd0;

    // Saturating good-transfer and error-response counters for debug.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            good_cnt <= 16'd0;
            err_cnt  <= 16'd0;
        end else if (state == RESP) begin
            if (err_q) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else begin
                if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Bench for uart_apb_bridge: three instances with RD_LAT 1, 0 and 3, each
// attached to a behavioural register file whose read data lags the read
// address by RD_LAT cycles. Expected responses come from a word-array model
// of the register file plus the address/strobe error rules.
module tb_uart_apb_bridge;

  localparam int N = 3;

  logic        clk;
  logic        reset;
  logic        psel[N];
  logic        penable[N];
  logic        pwrite[N];
  logic [7:0]  paddr[N];
  logic [31:0] pwdata[N];
  logic [3:0]  pstrb[N];
  logic [31:0] prdata[N];
  logic        pready[N];
  logic        pslverr[N];
  logic        reg_we[N];
  logic [4:0]  reg_waddr[N];
  logic [31:0] reg_wdata[N];
  logic [4:0]  reg_raddr[N];
  logic [31:0] reg_rdata[N];

  // register file stub state
  logic [31:0] stub_mem[N][32];
  logic [4:0]  h1[N];
  logic [4:0]  h2[N];
  logic [4:0]  h3[N];

  // monitor state
  int          we_cnt[N];
  int          pop_cnt[N];
  int          overlap_cnt[N];
  int          pready_cnt[N];
  logic [4:0]  last_waddr[N];
  logic [31:0] last_wdata[N];
  logic [4:0]  last_pop[N];

  // reference model
  logic [31:0] model_mem[N][32];
  int          good_tally[N];
  int          err_tally[N];
  int          resp_exp[N];

  int n_vec;
  int n_err;

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : (u == 1) ? 0 : 3;
  endfunction

  function automatic logic [31:0] seed_val(input int u, input int i);
    return 32'h1000_0000 * 32'(u + 1) + 32'h0001_0101 * 32'(i) + 32'h55;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    logic [4:0] rsel;
    assign rsel = (LAT == 0) ? reg_raddr[g] : (LAT == 1) ? h1[g] : (LAT == 2) ? h2[g] : h3[g];
    assign reg_rdata[g] = (rsel == 5'h1F) ? 32'hBAD0_BAD0 : stub_mem[g][rsel];
    uart_apb_bridge #(.NUM_REGS(8), .PARK_ADDR(5'h1F), .RD_LAT(LAT)) u_dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .psel_i     (psel[g]),
      .penable_i  (penable[g]),
      .pwrite_i   (pwrite[g]),
      .paddr_i    (paddr[g]),
      .pwdata_i   (pwdata[g]),
      .pstrb_i    (pstrb[g]),
      .prdata_o   (prdata[g]),
      .pready_o   (pready[g]),
      .pslverr_o  (pslverr[g]),
      .reg_we_o   (reg_we[g]),
      .reg_waddr_o(reg_waddr[g]),
      .reg_wdata_o(reg_wdata[g]),
      .reg_raddr_o(reg_raddr[g]),
      .reg_rdata_i(reg_rdata[g])
    );
  end

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file stub: reseeds on reset, writes on reg_we, delays read address
  always @(posedge clk) begin
    for (int u = 0; u < N; u++) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) stub_mem[u][i] <= seed_val(u, i);
      end else if (reg_we[u]) begin
        stub_mem[u][reg_waddr[u]] <= reg_wdata[u];
      end
      h1[u] <= reg_raddr[u];
      h2[u] <= h1[u];
      h3[u] <= h2[u];
    end
  end

  // regfile-side monitor
  always @(negedge clk) begin
    for (int u = 0; u < N; u++) begin
      if (reg_we[u]) begin
        we_cnt[u]     <= we_cnt[u] + 1;
        last_waddr[u] <= reg_waddr[u];
        last_wdata[u] <= reg_wdata[u];
      end
      if (reg_raddr[u] != 5'h1F) begin
        pop_cnt[u]  <= pop_cnt[u] + 1;
        last_pop[u] <= reg_raddr[u];
      end
      if (reg_we[u] && (reg_raddr[u] != 5'h1F)) overlap_cnt[u] <= overlap_cnt[u] + 1;
      if (pready[u]) pready_cnt[u] <= pready_cnt[u] + 1;
    end
  end

  task automatic model_reset();
    for (int u = 0; u < N; u++) begin
      for (int i = 0; i < 32; i++) model_mem[u][i] = seed_val(u, i);
      good_tally[u] = 0;
      err_tally[u]  = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int u = 0; u < N; u++) begin
      psel[u]    = 1'b0;
      penable[u] = 1'b0;
    end
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One APB transfer on instance u, checked against the model.
  task automatic xfer(input int u, input bit wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input bit drop, input string name);
    bit          err;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic [4:0]  idx;
    int          we0, pop0, lat, stray;
    bit          seen;
    idx     = addr[6:2];
    err     = (addr[1:0] != 2'b00) || addr[7] || (idx >= 5'd8) || (wr && (strb != 4'hF));
    exp_lat = err ? 2 : (wr ? 3 : 3 + lat_of(u));
    exp_rd  = (err || wr) ? 32'd0 : model_mem[u][idx];
    we0     = we_cnt[u];
    pop0    = pop_cnt[u];
    @(posedge clk); #1;
    psel[u]    = 1'b1;
    penable[u] = 1'b0;
    pwrite[u]  = wr;
    paddr[u]   = addr;
    pwdata[u]  = data;
    pstrb[u]   = strb;
    lat   = 0;
    seen  = 1'b0;
    stray = 0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        if (drop) psel[u] = 1'b0;
        else      penable[u] = 1'b1;
      end
      if (pready[u]) seen = 1'b1;
      else if ((pslverr[u] !== 1'b0) || (prdata[u] !== 32'd0)) stray++;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s u%0d timeout: no pready within %0d cycles, required at %0d", name, u, lat, exp_lat);
    end else begin
      n_vec++;
      if (lat !== exp_lat) begin
        n_err++;
        $display("FAIL %s u%0d latency: got %0d required %0d", name, u, lat, exp_lat);
      end
      n_vec++;
      if (pslverr[u] !== err) begin
        n_err++;
        $display("FAIL %s u%0d pslverr: got %0b required %0b", name, u, pslverr[u], err);
      end
      n_vec++;
      if (prdata[u] !== exp_rd) begin
        n_err++;
        $display("FAIL %s u%0d prdata: got %h required %h", name, u, prdata[u], exp_rd);
      end
    end
    n_vec++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL %s u%0d idle_resp: got %0d cycles with pslverr/prdata set while pready=0, required 0", name, u, stray);
    end
    n_vec++;
    if ((we_cnt[u] - we0) !== ((wr && !err) ? 1 : 0)) begin
      n_err++;
      $display("FAIL %s u%0d we_pulses: got %0d required %0d", name, u, we_cnt[u] - we0, (wr && !err) ? 1 : 0);
    end
    n_vec++;
    if ((pop_cnt[u] - pop0) !== ((!wr && !err) ? 1 : 0)) begin
      n_err++;
      $display("FAIL %s u%0d read_pops: got %0d required %0d", name, u, pop_cnt[u] - pop0, (!wr && !err) ? 1 : 0);
    end
    if (wr && !err) begin
      n_vec++;
      if ((last_waddr[u] !== idx) || (last_wdata[u] !== data)) begin
        n_err++;
        $display("FAIL %s u%0d write_port: got waddr=%0d wdata=%h required waddr=%0d wdata=%h",
                 name, u, last_waddr[u], last_wdata[u], idx, data);
      end
      model_mem[u][idx] = data;
    end
    if (!wr && !err) begin
      n_vec++;
      if (last_pop[u] !== idx) begin
        n_err++;
        $display("FAIL %s u%0d raddr: got %0d required %0d", name, u, last_pop[u], idx);
      end
    end
    if (err) err_tally[u]++;
    else     good_tally[u]++;
    resp_exp[u]++;
  endtask

  task automatic test_reset();
    do_reset(2);
    for (int u = 0; u < N; u++) begin
      n_vec++;
      if ((pready[u] !== 1'b0) || (pslverr[u] !== 1'b0) || (prdata[u] !== 32'd0)) begin
        n_err++;
        $display("FAIL reset_apb u%0d: got pready=%b pslverr=%b prdata=%h required 0/0/0", u, pready[u], pslverr[u], prdata[u]);
      end
      n_vec++;
      if ((reg_we[u] !== 1'b0) || (reg_waddr[u] !== 5'd0) || (reg_wdata[u] !== 32'd0) || (reg_raddr[u] !== 5'h1F)) begin
        n_err++;
        $display("FAIL reset_reg u%0d: got we=%b waddr=%0d wdata=%h raddr=%h required 0/0/0/1f",
                 u, reg_we[u], reg_waddr[u], reg_wdata[u], reg_raddr[u]);
      end
    end
    n_vec++;
    if ((g_inst[0].u_dut.good_cnt !== 16'd0) || (g_inst[0].u_dut.err_cnt !== 16'd0) || (g_inst[0].u_dut.cap_q !== 32'd0)) begin
      n_err++;
      $display("FAIL reset_debug: got good=%0d err=%0d cap=%h required 0/0/0",
               g_inst[0].u_dut.good_cnt, g_inst[0].u_dut.err_cnt, g_inst[0].u_dut.cap_q);
    end
  endtask

  task automatic test_write();
    xfer(0, 1'b1, 8'h08, 32'hA5A5_0013, 4'hF, 1'b0, "good_write");
    idle(2);
  endtask

  task automatic test_read();
    xfer(0, 1'b1, 8'h0C, 32'hDEAD_BEEF, 4'hF, 1'b0, "preload_idx3");
    idle(1);
    xfer(0, 1'b0, 8'h0C, 32'd0, 4'hF, 1'b0, "good_read");
    idle(2);
  endtask

  task automatic test_errors();
    xfer(0, 1'b0, 8'h0D, 32'd0, 4'hF, 1'b0, "err_unaligned");
    idle(1);
    xfer(0, 1'b0, 8'h40, 32'd0, 4'hF, 1'b0, "err_range");
    idle(1);
    xfer(0, 1'b1, 8'h08, 32'h1234_5678, 4'h3, 1'b0, "err_strobe");
    idle(1);
    xfer(0, 1'b0, 8'h84, 32'd0, 4'hF, 1'b0, "err_bit7");
    idle(1);
    xfer(0, 1'b0, 8'h1C, 32'd0, 4'h3, 1'b0, "read_partial_strb");
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    v = $urandom;
    xfer(0, 1'b1, 8'h04, v, 4'hF, 1'b0, "b2b_write");
    xfer(0, 1'b0, 8'h04, 32'd0, 4'hF, 1'b0, "b2b_read");
    xfer(0, 1'b0, 8'h0C, 32'd0, 4'hF, 1'b0, "b2b_read2");
    xfer(0, 1'b0, 8'h3C, 32'd0, 4'hF, 1'b0, "b2b_err");
    idle(2);
  endtask

  task automatic test_lat_sweep();
    for (int u = 1; u < N; u++) begin
      xfer(u, 1'b1, 8'h14, $urandom, 4'hF, 1'b0, "sweep_write");
      xfer(u, 1'b0, 8'h14, 32'd0, 4'hF, 1'b0, "sweep_read");
      idle(1);
      xfer(u, 1'b0, 8'h00, 32'd0, 4'hF, 1'b0, "sweep_read_seed");
      idle(1);
    end
  endtask

  task automatic test_psel_drop();
    int we0, rdy0;
    xfer(0, 1'b1, 8'h18, 32'h0BAD_F00D, 4'hF, 1'b1, "drop_write");
    idle(1);
    we0  = we_cnt[0];
    rdy0 = pready_cnt[0];
    idle(5);
    n_vec++;
    if ((we_cnt[0] != we0) || (pready_cnt[0] != rdy0)) begin
      n_err++;
      $display("FAIL drop_retrigger: got %0d extra we and %0d extra pready, required 0/0",
               we_cnt[0] - we0, pready_cnt[0] - rdy0);
    end
    xfer(0, 1'b0, 8'h18, 32'd0, 4'hF, 1'b1, "drop_read");
    idle(2);
  endtask

  task automatic test_reset_mid();
    int we0, pop0, rdy0;
    we0  = we_cnt[0];
    pop0 = pop_cnt[0];
    rdy0 = pready_cnt[0];
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h08; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    reset      = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    n_vec++;
    if (reg_raddr[0] !== 5'h1F) begin
      n_err++;
      $display("FAIL reset_mid_raddr: got %h required 1f", reg_raddr[0]);
    end
    idle(6);
    n_vec++;
    if ((pready_cnt[0] != rdy0) || (we_cnt[0] != we0) || (pop_cnt[0] != pop0)) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got pready=%0d we=%0d pops=%0d after reset, required 0/0/0",
               pready_cnt[0] - rdy0, we_cnt[0] - we0, pop_cnt[0] - pop0);
    end
    xfer(0, 1'b0, 8'h08, 32'd0, 4'hF, 1'b0, "read_after_reset");
    idle(2);
  endtask

  task automatic test_random();
    logic [4:0]  idx;
    logic [1:0]  lo;
    logic        hi;
    logic [3:0]  strb;
    int          gap;
    for (int u = 0; u < N; u++) begin
      for (int k = 0; k < 30; k++) begin
        idx  = 5'($urandom_range(0, 9));
        lo   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        hi   = ($urandom_range(0, 9) == 0);
        strb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        xfer(u, 1'($urandom_range(0, 1)), {hi, idx, lo}, $urandom, strb, 1'b0, "random");
        gap = $urandom_range(0, 2);
        if (gap > 0) idle(gap);
      end
      idle(2);
    end
  endtask

  task automatic test_final_checks();
    idle(3);
    n_vec++;
    if ((g_inst[0].u_dut.good_cnt !== 16'(good_tally[0])) || (g_inst[0].u_dut.err_cnt !== 16'(err_tally[0]))) begin
      n_err++;
      $display("FAIL counters: got good=%0d err=%0d required good=%0d err=%0d",
               g_inst[0].u_dut.good_cnt, g_inst[0].u_dut.err_cnt, good_tally[0], err_tally[0]);
    end
    for (int u = 0; u < N; u++) begin
      n_vec++;
      if (overlap_cnt[u] != 0) begin
        n_err++;
        $display("FAIL we_raddr_overlap u%0d: got %0d cycles required 0", u, overlap_cnt[u]);
      end
      n_vec++;
      if (pready_cnt[u] != resp_exp[u]) begin
        n_err++;
        $display("FAIL pready_pulses u%0d: got %0d cycles required %0d", u, pready_cnt[u], resp_exp[u]);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    for (int u = 0; u < N; u++) begin
      psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
      paddr[u] = 8'd0; pwdata[u] = 32'd0; pstrb[u] = 4'h0;
      we_cnt[u] = 0; pop_cnt[u] = 0; overlap_cnt[u] = 0; pready_cnt[u] = 0;
      resp_exp[u] = 0;
    end
    model_reset();
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_back_to_back();
    test_lat_sweep();
    test_psel_drop();
    test_reset_mid();
    test_random();
    test_final_checks();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_apb_bridge.md
UART_APB_BRIDGE -- requirements
Module: uart_apb_bridge

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 8, giving the count of valid word registers; register index range is 0..NUM_REGS-1.
REQ-002 The block SHALL have parameter PARK_ADDR, default 5'h1F, giving the value driven on reg_raddr_o whenever no read is in progress; it is never a register with read side effects.
REQ-003 The block SHALL have parameter RD_LAT, default 1, giving the cycles from reg_raddr_o presentation to valid reg_rdata_i; legal values are 0..3.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  clock (all logic rising-edge); reset_i  in  1  synchronous active-high reset.
REQ-005 The block SHALL have APB ports: psel_i in 1; penable_i in 1; pwrite_i in 1; paddr_i in 8 (byte address); pwdata_i in 32; pstrb_i in 4; prdata_o out 32; pready_o out 1; pslverr_o out 1.
REQ-006 The block SHALL have regfile ports: reg_we_o out 1 (write strobe); reg_waddr_o out 5; reg_wdata_o out 32; reg_raddr_o out 5; reg_rdata_i in 32.

Function
REQ-007 The block SHALL use an FSM with states IDLE, WR, RD_WAIT, RD_CAP and RESP.
REQ-008 From IDLE, psel_i=1 and penable_i=0 (setup) SHALL latch paddr_i, pwdata_i, pwrite_i and pstrb_i, then decode an error.
REQ-009 An error SHALL be flagged when any of these holds: paddr_i[1:0]!=0; paddr_i[7]!=0; paddr_i[6:2]>=NUM_REGS; or, on a write, pstrb_i!=4'hF.
REQ-010 Erroneous transfers SHALL go to RESP, SHALL NOT assert reg_we_o, and SHALL NOT move reg_raddr_o off PARK_ADDR.
REQ-011 A good write SHALL go to WR, where reg_we_o=1 for exactly one cycle, with reg_waddr_o=paddr[6:2] and reg_wdata_o=latched pwdata, before moving to RESP.
REQ-012 A good read SHALL drive reg_raddr_o=paddr[6:2] for exactly one cycle (the first RD_WAIT cycle) and PARK_ADDR otherwise, so that a read-popped FIFO advances exactly once per APB read.
REQ-013 The block SHALL sample reg_rdata_i RD_LAT cycles after reg_raddr_o presentation into a capture register (state RD_CAP), then move to RESP; when RD_LAT=0, capture SHALL occur in the presentation cycle.
REQ-014 In RESP, pready_o=1 for one cycle; pslverr_o=error flag; prdata_o=capture register on a good read and 32'h0 on writes and errors; the FSM then returns to IDLE.
REQ-015 pready_o SHALL be 0 in all states except RESP, and pslverr_o and prdata_o SHALL be 0 whenever pready_o=0.
REQ-016 Good-read latency from setup cycle to pready SHALL be 3+RD_LAT cycles; good-write latency SHALL be 3 cycles; error latency SHALL be 2 cycles.
REQ-017 If psel_i drops before RESP (protocol violation), the block SHALL complete the internal sequence without aborting, because a started write or read pop is not revocable, and SHALL return to IDLE without retriggering.
REQ-018 Back-to-back transfers SHALL be accepted: a setup seen in the cycle after RESP SHALL start a new transfer with no idle gap required.
REQ-019 In the same cycle as reg_we_o, reg_raddr_o SHALL equal PARK_ADDR, so a write and a read never occur simultaneously.
REQ-020 The block SHALL keep 16-bit saturating counters for good transfers and error responses, exposed only through hierarchical debug; they do not wrap past 16'hFFFF.

Reset
REQ-021 While reset_i=1 at a clock edge, the FSM SHALL go to IDLE with: reg_we_o=0; reg_waddr_o=0; reg_wdata_o=0; reg_raddr_o=PARK_ADDR; pready_o=0; pslverr_o=0; prdata_o=0; capture register=0; counters=0.
REQ-022 Reset asserted mid-transfer SHALL abandon the transfer: no reg_we_o and no pready_o may follow until a new setup phase.

Verification
REQ-023 Good write: setup with paddr=8'h08, pwdata=32'hA5A5_0013, pstrb=F -> reg_we_o=1 for exactly one cycle with waddr=2 and wdata=A5A5_0013; pready=1 and pslverr=0 three cycles after setup.
REQ-024 Good read with RD_LAT=1 and regfile returning 32'hDEAD_BEEF at index 3: paddr=8'h0C -> reg_raddr_o=3 for exactly one cycle, otherwise 5'h1F; prdata=DEAD_BEEF with pready four cycles after setup.
REQ-025 Errors: paddr=8'h0D, then paddr=8'h40 (index 16 >= 8), then a write with pstrb=4'h3 -> each gives pslverr=1 and prdata=0 two cycles after setup, with no reg_we_o and reg_raddr_o held at 1F.
REQ-026 Back-to-back: write index 1, then read index 1 starting the cycle after RESP -> the read returns the written value, and reg_we_o and the non-park raddr never overlap.
REQ-027 Reset in the RD_WAIT cycle -> no pready follows; reg_raddr_o=1F the next cycle; a subsequent read completes normally.
REQ-028 Sweep RD_LAT over 0 and 3 -> read latency equals 3+RD_LAT, with correct captured data each time.
